// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: state sequencing, datapath control decode,
// memory-handshake timeout and sticky error flags.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       les,
  input  logic       upper,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic       Jal,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [1:0] RegWrite,
  output logic [1:0] sRdD,
  output logic [3:0] state,
  output logic       halted,
  output logic       illegal_op,
  output logic       bus_timeout,
  output logic       retire
);

  // state    | meaning
  // FETCH    | read instruction, PC+4, wait mem_ready
  // DECODE   | latch opcode, precompute branch target
  // MEM_ADDR | compute load/store address
  // MEM_RD   | data read, wait mem_ready
  // WB_MEM   | write loaded data to rt
  // MEM_WR   | data write, wait mem_ready
  // EXEC_R   | R-type ALU operation
  // WB_R     | write ALU result to rd
  // BRANCH   | beq/bne compare and conditional PC update
  // JUMP     | PC <- jump target
  // JAL      | PC <- jump target, link register write
  // HALT     | stopped until reset
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_WB_MEM   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  state_t          st;
  logic [5:0]      op_q;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            ready_q;

  assign to_hit = (to_cnt == TO_W'(MEM_TIMEOUT - 1));
  // Handshake terms are held off while reset is asserted.
  assign ready_q = mem_ready & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= S_FETCH;
      op_q        <= 6'd0;
      to_cnt      <= '0;
      illegal_op  <= 1'b0;
      bus_timeout <= 1'b0;
    end else begin
      to_cnt <= '0;
      case (st)
        S_FETCH, S_MEM_RD, S_MEM_WR: begin
          if (mem_ready) begin
            case (st)
              S_FETCH:  st <= S_DECODE;
              S_MEM_RD: st <= S_WB_MEM;
              default:  st <= S_FETCH;
            endcase
          end else if (to_hit) begin
            st          <= S_HALT;
            bus_timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          op_q <= opcode;
          case (opcode)
            6'h00:        st <= S_EXEC_R;
            6'h23, 6'h2B: st <= S_MEM_ADDR;
            6'h04, 6'h05: st <= S_BRANCH;
            6'h02:        st <= S_JUMP;
            6'h03:        st <= S_JAL;
            default: begin
              st         <= S_HALT;
              illegal_op <= 1'b1;
            end
          endcase
        end
        S_MEM_ADDR: st <= (op_q == 6'h23) ? S_MEM_RD : S_MEM_WR;
        S_EXEC_R:   st <= S_WB_R;
        S_WB_MEM, S_WB_R, S_BRANCH, S_JUMP, S_JAL: st <= S_FETCH;
        S_HALT:     st <= S_HALT;
        default:    st <= S_HALT;
      endcase
    end
  end

  assign state  = st;
  assign halted = (st == S_HALT);

  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    MemtoReg = 1'b0;
    RegDst   = 1'b0;
    ALUSrcA  = 1'b0;
    Jal      = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSource = 2'b00;
    RegWrite = 2'b00;
    sRdD     = 2'b00;
    retire   = 1'b0;
    case (st)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = ready_q;
        PCWrite = ready_q;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_WB_MEM: begin
        RegWrite = 2'b01;
        MemtoReg = 1'b1;
        retire   = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        retire   = ready_q;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_WB_R: begin
        RegDst   = 1'b1;
        RegWrite = 2'b11;
        retire   = 1'b1;
        if (les)        sRdD = 2'b01;
        else if (upper) sRdD = 2'b10;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSource = 2'b01;
        PCWrite  = ((op_q == 6'h04) && zero) || ((op_q == 6'h05) && !zero);
        retire   = 1'b1;
      end
      S_JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
        retire   = 1'b1;
      end
      S_JAL: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
        Jal      = 1'b1;
        RegWrite = 2'b01;
        retire   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control words
// go through a scoreboard queue and are compared against the DUT outputs.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero, les, upper, mem_ready;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, ALUSrcA, Jal;
  logic [1:0] ALUSrcB, ALUOp, PCSource, RegWrite, sRdD;
  logic [3:0] state;
  logic       halted, illegal_op, bus_timeout, retire;

  int checks = 0;
  int passes = 0;
  logic exp_ill = 1'b0;
  logic exp_to  = 1'b0;
  logic [26:0] exp_q[$];
  string       tag_q[$];

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3,
                         WB_MEM = 4'd4, MEM_WR = 4'd5, EXEC_R = 4'd6, WB_R = 4'd7,
                         BRANCH = 4'd8, JUMP = 4'd9, JAL = 4'd10, HALT = 4'd11;

  multicycle_control #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .les(les), .upper(upper),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .Jal(Jal), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .RegWrite(RegWrite), .sRdD(sRdD), .state(state), .halted(halted),
    .illegal_op(illegal_op), .bus_timeout(bus_timeout), .retire(retire)
  );

  always #5 clk = ~clk;

  // Expected outputs for a state, written from the control table.
  function automatic logic [26:0] ctrl_exp(input logic [3:0] st, input logic mr, input logic zr,
                                           input logic [5:0] op, input logic ls, input logic up,
                                           input logic ill, input logic tmo);
    logic pcw, iord, mrd, mwr, irw, m2r, rdst, asa, jl, hlt, ret;
    logic [1:0] asb, aop, pcs, rw, srd;
    {pcw, iord, mrd, mwr, irw, m2r, rdst, asa, jl, hlt, ret} = '0;
    {asb, aop, pcs, rw, srd} = '0;
    case (st)
      FETCH:    begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      DECODE:   asb = 2'b11;
      MEM_ADDR: begin asa = 1; asb = 2'b10; end
      MEM_RD:   begin mrd = 1; iord = 1; end
      WB_MEM:   begin rw = 2'b01; m2r = 1; ret = 1; end
      MEM_WR:   begin mwr = 1; iord = 1; ret = mr; end
      EXEC_R:   begin asa = 1; aop = 2'b10; end
      WB_R:     begin rdst = 1; rw = 2'b11; ret = 1; srd = ls ? 2'b01 : (up ? 2'b10 : 2'b00); end
      BRANCH:   begin asa = 1; aop = 2'b01; pcs = 2'b01; ret = 1;
                      pcw = (op == 6'h04) ? zr : ((op == 6'h05) ? !zr : 1'b0); end
      JUMP:     begin pcs = 2'b10; pcw = 1; ret = 1; end
      JAL:      begin pcs = 2'b10; pcw = 1; jl = 1; rw = 2'b01; ret = 1; end
      default:  hlt = 1;
    endcase
    return {st, pcw, iord, mrd, mwr, irw, m2r, rdst, asa, jl, asb, aop, pcs, rw, srd,
            hlt, ill, tmo, ret};
  endfunction

  task automatic step(input string tag, input logic [3:0] es, input logic mr);
    logic [26:0] obs, e;
    string t;
    mem_ready = mr;
    #1;
    exp_q.push_back(ctrl_exp(es, mr & rst_n, zero, opcode, les, upper, exp_ill, exp_to));
    tag_q.push_back(tag);
    #1;
    obs = {state, PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, ALUSrcA, Jal,
           ALUSrcB, ALUOp, PCSource, RegWrite, sRdD, halted, illegal_op, bus_timeout, retire};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) passes++;
    else $error("FAIL %s observed=%h expected=%h", t, obs, e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; opcode = 6'h00; zero = 1'b0; les = 1'b0; upper = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    step("reset_fetch", FETCH, 1'b1);
    rst_n = 1'b1;

    // lw with mem_ready on the third cycle of each request
    opcode = 6'h23;
    step("lw_f0", FETCH, 0); step("lw_f1", FETCH, 0); step("lw_f2", FETCH, 1);
    step("lw_dec", DECODE, 1); step("lw_addr", MEM_ADDR, 1);
    step("lw_rd0", MEM_RD, 0); step("lw_rd1", MEM_RD, 0); step("lw_rd2", MEM_RD, 1);
    step("lw_wb", WB_MEM, 1);

    // beq taken, ready arriving on the last allowed FETCH cycle
    opcode = 6'h04; zero = 1'b1;
    step("beq_f0", FETCH, 0); step("beq_f1", FETCH, 0); step("beq_f2", FETCH, 0);
    step("beq_f3_ready_wins", FETCH, 1);
    step("beq_dec", DECODE, 0); step("beq_taken", BRANCH, 1);
    zero = 1'b0;
    step("beq2_f", FETCH, 1); step("beq2_dec", DECODE, 0); step("beq_not_taken", BRANCH, 0);
    opcode = 6'h05;
    step("bne_f", FETCH, 1); step("bne_dec", DECODE, 0); step("bne_taken", BRANCH, 0);

    // R-type with both comparison flags: les has priority
    opcode = 6'h00; les = 1'b1; upper = 1'b1;
    step("r_f", FETCH, 1); step("r_dec", DECODE, 1); step("r_exec", EXEC_R, 1);
    step("r_wb_les", WB_R, 0);
    les = 1'b0;
    step("r2_f", FETCH, 1); step("r2_dec", DECODE, 0); step("r2_exec", EXEC_R, 0);
    step("r2_wb_upper", WB_R, 0);
    upper = 1'b0;

    opcode = 6'h02;
    step("j_f", FETCH, 1); step("j_dec", DECODE, 0); step("j_jump", JUMP, 0);
    opcode = 6'h03;
    step("jal_f", FETCH, 1); step("jal_dec", DECODE, 0); step("jal_jal", JAL, 0);

    // sw with mem_ready on the 4th MEM_WR cycle
    opcode = 6'h2B;
    step("sw_f", FETCH, 1); step("sw_dec", DECODE, 0); step("sw_addr", MEM_ADDR, 0);
    step("sw_w0", MEM_WR, 0); step("sw_w1", MEM_WR, 0); step("sw_w2", MEM_WR, 0);
    step("sw_w3_ready", MEM_WR, 1);

    // asynchronous reset in the middle of a MEM_RD wait
    opcode = 6'h23;
    step("lw2_f", FETCH, 1); step("lw2_dec", DECODE, 0); step("lw2_addr", MEM_ADDR, 0);
    step("lw2_rd0", MEM_RD, 0);
    #2 rst_n = 1'b0;
    step("async_rst", FETCH, 1);
    rst_n = 1'b1;

    // illegal opcode halts and ignores mem_ready afterwards
    opcode = 6'h3F;
    step("ill_f", FETCH, 1); step("ill_dec", DECODE, 0);
    exp_ill = 1'b1;
    step("ill_halt0", HALT, 1); step("ill_halt1", HALT, 0); step("ill_halt2", HALT, 1);
    rst_n = 1'b0; exp_ill = 1'b0;
    step("ill_reset", FETCH, 0);
    rst_n = 1'b1;

    // sw with mem_ready never arriving times out into HALT
    opcode = 6'h2B;
    step("swto_f", FETCH, 1); step("swto_dec", DECODE, 0); step("swto_addr", MEM_ADDR, 0);
    step("swto_w0", MEM_WR, 0); step("swto_w1", MEM_WR, 0); step("swto_w2", MEM_WR, 0);
    step("swto_w3", MEM_WR, 0);
    exp_to = 1'b1;
    step("swto_halt0", HALT, 1); step("swto_halt1", HALT, 0);
    rst_n = 1'b0; exp_to = 1'b0;
    step("final_reset", FETCH, 0);
    rst_n = 1'b1;
    step("final_fetch", FETCH, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
